// File: rtl/sram_s011hd1p_x32y2d128_bw_if.sv
// ---------------------------------------------------------------------------
// sram_s011hd1p_x32y2d128_bw_if
// Purpose : Bundles the single-port SRAM access signals so that the requester
//           and the macro share one connection.
// Signals : CEN  - chip enable, active-low (1 = idle)
//           WEN  - write enable, active-low (0 = write, 1 = read)
//           BWEN - per-bit write enable, active-low
//           A    - word address
//           D    - write data
//           Q    - registered read data (driven by the memory)
// Modports: master - requester side (drives CEN/WEN/BWEN/A/D, samples Q)
//           slave  - memory side   (samples CEN/WEN/BWEN/A/D, drives Q)
// ---------------------------------------------------------------------------
interface sram_s011hd1p_x32y2d128_bw_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 6
);
    logic                  CEN;
    logic                  WEN;
    logic [DATA_WIDTH-1:0] BWEN;
    logic [ADDR_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] D;
    logic [DATA_WIDTH-1:0] Q;

    modport master (
        output CEN,
        output WEN,
        output BWEN,
        output A,
        output D,
        input  Q
    );

    modport slave (
        input  CEN,
        input  WEN,
        input  BWEN,
        input  A,
        input  D,
        output Q
    );
endinterface

// File: rtl/sram_s011hd1p_x32y2d128_bw.sv
// ---------------------------------------------------------------------------
// sram_s011hd1p_x32y2d128_bw
// Purpose : Behavioural single-port SRAM, DEPTH x DATA_WIDTH, with per-bit
//           write masking and a registered read port (1-cycle latency).
// Ports   : clk - clock, all state changes on the rising edge
//           rst - synchronous, active-high; clears Q and blocks the access
//                 of that cycle, but leaves the array contents untouched
//           bus - slave modport of sram_s011hd1p_x32y2d128_bw_if
//                 (CEN, WEN, BWEN, A, D in; Q out)
// Notes   : The array starts at all zeros so reads before any write return 0
//           regardless of when rst is applied. Q only changes on a read edge
//           or a reset edge; writes never forward data onto Q.
// ---------------------------------------------------------------------------
module sram_s011hd1p_x32y2d128_bw #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    sram_s011hd1p_x32y2d128_bw_if.slave     bus
);

    // Storage array, zero at time 0 (reset does not touch it).
    logic [DATA_WIDTH-1:0] mem_r [DEPTH] = '{default: {DATA_WIDTH{1'b0}}};

    // Registered read data.
    logic [DATA_WIDTH-1:0] q_r;

    // Decoded access strobes for the current cycle.
    logic                  rd_en_s;
    logic                  wr_en_s;

    // Bits of the addressed word after applying the active-low bit mask:
    // a 1 in n_mask keeps the old bit, a 0 takes the new bit.
    function automatic logic [DATA_WIDTH-1:0] bit_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [DATA_WIDTH-1:0] n_mask
    );
        return (old_word & n_mask) | (new_word & ~n_mask);
    endfunction

    // Access decode: reset wins over any request, CEN=1 means idle.
    always_comb begin
        rd_en_s = 1'b0;
        wr_en_s = 1'b0;
        if (rst) begin
            rd_en_s = 1'b0;
            wr_en_s = 1'b0;
        end else if (!bus.CEN) begin
            if (bus.WEN) begin
                rd_en_s = 1'b1;
                wr_en_s = 1'b0;
            end else begin
                rd_en_s = 1'b0;
                wr_en_s = 1'b1;
            end
        end else begin
            rd_en_s = 1'b0;
            wr_en_s = 1'b0;
        end
    end

    // Array write: masked merge into the addressed word.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[bus.A] <= bit_merge(mem_r[bus.A], bus.D, bus.BWEN);
        end
    end

    // Read port register: cleared by reset, loaded on reads, held otherwise
    // (including write cycles, so there is no write-through).
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= {DATA_WIDTH{1'b0}};
        end else if (rd_en_s) begin
            q_r <= mem_r[bus.A];
        end else begin
            q_r <= q_r;
        end
    end

    assign bus.Q = q_r;

endmodule

// File: tb/tb_sram_s011hd1p_x32y2d128_bw.sv
// ---------------------------------------------------------------------------
// tb_sram_s011hd1p_x32y2d128_bw
// Drives directed and random accesses into the SRAM. Each driven cycle
// pushes the Q value the memory must show after that edge into a queue;
// an independent monitor pops one entry per clock and compares with Q.
// ---------------------------------------------------------------------------
module tb_sram_s011hd1p_x32y2d128_bw;

    localparam int DW    = 128;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    typedef struct {
        logic [DW-1:0] q;
        string         tag;
    } exp_t;

    logic clk;
    logic rst;

    sram_s011hd1p_x32y2d128_bw_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sram_s011hd1p_x32y2d128_bw #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] model_q;
    exp_t          exp_q [$];

    int n_checks;
    int n_fail;
    int cyc_no;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one comparison per clock whenever an expectation is queued.
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc_no = cyc_no + 1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks = n_checks + 1;
            if (bus.Q !== e.q) begin
                n_fail = n_fail + 1;
                $display("FAIL %s cycle %0d: Q=%h expected %h", e.tag, cyc_no, bus.Q, e.q);
            end
        end
    end

    // One clock of stimulus plus the expected Q after that edge.
    task automatic do_cycle(input logic r, input logic c, input logic w,
                            input logic [DW-1:0] bw, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input string tag);
        exp_t e;
        @(negedge clk);
        rst      = r;
        bus.CEN  = c;
        bus.WEN  = w;
        bus.BWEN = bw;
        bus.A    = a;
        bus.D    = d;
        if (r) begin
            model_q = '0;
        end else if (!c) begin
            if (w) model_q = ref_mem[a];
            else   ref_mem[a] = (ref_mem[a] & bw) | (d & ~bw);
        end
        e.q   = model_q;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [DW-1:0] ones;
    logic [DW-1:0] zeros;
    logic [DW-1:0] pat;
    logic [DW-1:0] mask71;
    logic [DW-1:0] val_x;
    logic [DW-1:0] val_y;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc_no   = 0;
        model_q  = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ones   = '1;
        zeros  = '0;
        pat    = 128'h0123456789ABCDEF0123456789ABCDEF;
        mask71 = ~(128'hFF << 64);
        val_x  = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
        val_y  = 128'h5A5A_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999;
        rst = 1'b1; bus.CEN = 1'b1; bus.WEN = 1'b1;
        bus.BWEN = ones; bus.A = '0; bus.D = '0;

        // Reset then read of power-up contents
        do_cycle(1'b1, 1'b1, 1'b1, ones, 6'd0, zeros, "reset_q");
        do_cycle(1'b0, 1'b0, 1'b1, ones, 6'd5, zeros, "powerup_read");

        // Full-word write, Q held during write, then read back
        do_cycle(1'b0, 1'b0, 1'b1, ones, 6'd3, zeros, "read3_before");
        do_cycle(1'b0, 1'b0, 1'b0, zeros, 6'd3, pat, "q_hold_on_write");
        do_cycle(1'b0, 1'b0, 1'b1, ones, 6'd3, zeros, "read_pattern");

        // Mask merge on bits 71:64
        do_cycle(1'b0, 1'b0, 1'b0, zeros, 6'd7, ones, "write7_ones");
        do_cycle(1'b0, 1'b0, 1'b0, mask71, 6'd7, zeros, "write7_masked");
        do_cycle(1'b0, 1'b0, 1'b1, ones, 6'd7, zeros, "read_merged");
        // BWEN all ones leaves memory unchanged
        do_cycle(1'b0, 1'b0, 1'b0, ones, 6'd7, zeros, "write_nomask");
        do_cycle(1'b0, 1'b0, 1'b1, ones, 6'd7, zeros, "read_after_nomask");

        // CEN=1 blocks a write and holds Q
        do_cycle(1'b0, 1'b0, 1'b1, ones, 6'd3, zeros, "read3_again");
        do_cycle(1'b0, 1'b1, 1'b0, zeros, 6'd3, zeros, "cen_hold_wr");
        do_cycle(1'b0, 1'b1, 1'b1, zeros, 6'd7, ones, "cen_hold_rd");
        do_cycle(1'b0, 1'b0, 1'b1, ones, 6'd3, zeros, "read3_after_cen");

        // Back-to-back write/read and top address
        do_cycle(1'b0, 1'b0, 1'b0, zeros, 6'd10, 128'd1, "write10");
        do_cycle(1'b0, 1'b0, 1'b1, ones, 6'd10, zeros, "read10_next");
        do_cycle(1'b0, 1'b0, 1'b1, ones, 6'd11, zeros, "read11");
        do_cycle(1'b0, 1'b0, 1'b0, zeros, 6'd63, pat ^ ones, "write63");
        do_cycle(1'b0, 1'b0, 1'b1, ones, 6'd63, zeros, "read63");

        // Reset blocks a coinciding write, contents survive
        do_cycle(1'b0, 1'b0, 1'b0, zeros, 6'd4, val_x, "write4_x");
        do_cycle(1'b1, 1'b0, 1'b0, zeros, 6'd4, val_y, "rst_blocks_wr");
        do_cycle(1'b0, 1'b0, 1'b1, ones, 6'd4, zeros, "read4_after_rst");
        do_cycle(1'b0, 1'b0, 1'b1, ones, 6'd3, zeros, "read3_after_rst");
        // Reset blocks a coinciding read
        do_cycle(1'b1, 1'b0, 1'b1, ones, 6'd3, zeros, "rst_blocks_rd");

        // Random traffic, biased to a few addresses to create hits
        for (int i = 0; i < 600; i++) begin
            logic          r;
            logic          c;
            logic          w;
            logic [DW-1:0] bw;
            logic [AW-1:0] a;
            int            sel;
            r   = ($urandom_range(0, 24) == 0);
            c   = ($urandom_range(0, 4) == 0);
            w   = $urandom_range(0, 1) == 1;
            sel = $urandom_range(0, 3);
            case (sel)
                0:       bw = zeros;
                1:       bw = ones;
                default: bw = rnd128();
            endcase
            if ($urandom_range(0, 1) == 1) a = AW'($urandom_range(0, 7));
            else                           a = AW'($urandom_range(0, DEPTH - 1));
            do_cycle(r, c, w, bw, a, rnd128(), "random");
        end

        // Sweep read of every word against the model
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1'b0, 1'b0, 1'b1, ones, AW'(i), zeros, "sweep_read");
        end
        do_cycle(1'b0, 1'b1, 1'b1, ones, 6'd0, zeros, "final_idle");

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_checks = n_checks + 1;
            n_fail   = n_fail + 1;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
